// File: rtl/hazard_ctrl_if.sv
// Hazard information from the pipeline and the stage-control signals returned to it.
// The master modport is the datapath side and the slave modport is the controller side.
interface hazard_ctrl_if;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rs;
  logic       id_uses_rt;
  logic [4:0] ex_reg_dest;
  logic       ex_wb_en;
  logic       ex_mem_r_en;
  logic       ex_md_op;
  logic       md_done;
  logic       br_taken_ex;
  logic       mem_access;
  logic       dmem_ready;

  logic       pc_en;
  logic       if_id_en;
  logic       id_ex_en;
  logic       ex_mem_en;
  logic       mem_wb_en;
  logic       if_id_flush;
  logic       id_ex_flush;
  logic       ex_mem_flush;
  logic       md_start;
  logic       busy_md;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_reg_dest, ex_wb_en,
           ex_mem_r_en, ex_md_op, md_done, br_taken_ex, mem_access, dmem_ready,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, ex_mem_flush, md_start, busy_md
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_reg_dest, ex_wb_en,
           ex_mem_r_en, ex_md_op, md_done, br_taken_ex, mem_access, dmem_ready,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, ex_mem_flush, md_start, busy_md
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage core: stage enables/flushes for
// load-use, taken branches, multiply/divide waits and dmem wait states, plus perf counters.
module hazard_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  hazard_ctrl_if.slave     hz,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic {RUN, MD_WAIT} state_e;

  state_e           state_q, state_d;
  logic             md_pending_q, md_pending_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  logic [4:0] en;     // {pc, if_id, id_ex, ex_mem, mem_wb}
  logic [2:0] flush;  // {if_id, id_ex, ex_mem}
  logic       md_start;
  logic       branch_flush;
  logic       mem_stall;
  logic       load_use;

  assign mem_stall = hz.mem_access & ~hz.dmem_ready;
  assign load_use  = hz.ex_mem_r_en & hz.ex_wb_en & (hz.ex_reg_dest != 5'd0) &
                     ((hz.id_uses_rs & (hz.id_rs == hz.ex_reg_dest)) |
                      (hz.id_uses_rt & (hz.id_rt == hz.ex_reg_dest)));

  always_comb begin
    en           = '0;
    flush        = '0;
    md_start     = 1'b0;
    branch_flush = 1'b0;
    state_d      = state_q;
    md_pending_d = md_pending_q;
    // Outputs are gated by rst_n so the pipeline is fully frozen while reset is held.
    if (rst_n) begin
      unique case (state_q)
        RUN: begin
          if (mem_stall) begin
            en = '0;
          end else if (hz.br_taken_ex) begin
            en           = '1;
            flush        = 3'b110;
            branch_flush = 1'b1;
          end else if (hz.ex_md_op) begin
            md_start = 1'b1;
            en       = 5'b00011;
            flush    = 3'b001;
            state_d  = MD_WAIT;
          end else if (load_use) begin
            en    = 5'b00111;
            flush = 3'b010;
          end else begin
            en = '1;
          end
        end
        MD_WAIT: begin
          if (mem_stall) begin
            // A result arriving under a memory stall is remembered for the release.
            if (hz.md_done) md_pending_d = 1'b1;
          end else if (hz.md_done || md_pending_q) begin
            en           = '1;
            md_pending_d = 1'b0;
            state_d      = RUN;
          end else begin
            en    = 5'b00011;
            flush = 3'b001;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (cnt_clr) begin
      stall_d = '0;
      flush_d = '0;
    end else begin
      if (!en[4] && (stall_q != '1)) stall_d = stall_q + 1'b1;
      if (branch_flush && (flush_q != '1)) flush_d = flush_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      md_pending_q <= 1'b0;
      stall_q      <= '0;
      flush_q      <= '0;
    end else begin
      state_q      <= state_d;
      md_pending_q <= md_pending_d;
      stall_q      <= stall_d;
      flush_q      <= flush_d;
    end
  end

  assign hz.pc_en        = en[4];
  assign hz.if_id_en     = en[3];
  assign hz.id_ex_en     = en[2];
  assign hz.ex_mem_en    = en[1];
  assign hz.mem_wb_en    = en[0];
  assign hz.if_id_flush  = flush[2];
  assign hz.id_ex_flush  = flush[1];
  assign hz.ex_mem_flush = flush[0];
  assign hz.md_start     = md_start;
  assign hz.busy_md      = (state_q == MD_WAIT);
  assign stall_cycles    = stall_q;
  assign flush_count     = flush_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (CNT_W=4 so counter saturation is reachable quickly).
module tb_hazard_ctrl;
  localparam int unsigned CW = 4;

  // Packed view: {pc, if_id, id_ex, ex_mem, mem_wb, if_id_fl, id_ex_fl, ex_mem_fl, md_start}
  localparam logic [8:0] O_NONE   = 9'b00000_000_0;
  localparam logic [8:0] O_RUN    = 9'b11111_000_0;
  localparam logic [8:0] O_LU     = 9'b00111_010_0;
  localparam logic [8:0] O_BR     = 9'b11111_110_0;
  localparam logic [8:0] O_MDST   = 9'b00011_001_1;
  localparam logic [8:0] O_FREEZE = 9'b00011_001_0;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cnt_clr = 1'b0;
  logic [CW-1:0] stall_cycles, flush_count;
  int            n_cmp = 0;
  int            n_bad = 0;

  hazard_ctrl_if hz ();

  hazard_ctrl #(.CNT_W(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .hz           (hz.slave),
    .cnt_clr      (cnt_clr),
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] outs();
    return {hz.pc_en, hz.if_id_en, hz.id_ex_en, hz.ex_mem_en, hz.mem_wb_en,
            hz.if_id_flush, hz.id_ex_flush, hz.ex_mem_flush, hz.md_start};
  endfunction

  task automatic idle();
    hz.id_rs = 5'd0; hz.id_rt = 5'd0; hz.id_uses_rs = 1'b0; hz.id_uses_rt = 1'b0;
    hz.ex_reg_dest = 5'd0; hz.ex_wb_en = 1'b0; hz.ex_mem_r_en = 1'b0;
    hz.ex_md_op = 1'b0; hz.md_done = 1'b0; hz.br_taken_ex = 1'b0;
    hz.mem_access = 1'b0; hz.dmem_ready = 1'b1;
  endtask

  // Advance one clock; inputs change 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_counters();
    idle();
    cnt_clr = 1'b1;
    cyc();
    cnt_clr = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    #2;
    n_cmp++; if (outs() !== O_NONE) begin $display("FAIL reset_outs got %b want %b", outs(), O_NONE); n_bad++; end
    n_cmp++; if (hz.busy_md !== 1'b0) begin $display("FAIL reset_busy got %b want 0", hz.busy_md); n_bad++; end
    n_cmp++; if (stall_cycles !== '0 || flush_count !== '0) begin
      $display("FAIL reset_cnt got %0d/%0d want 0/0", stall_cycles, flush_count); n_bad++; end
    cyc();
    rst_n = 1'b1;
    #1;
    n_cmp++; if (outs() !== O_RUN) begin $display("FAIL post_reset_run got %b want %b", outs(), O_RUN); n_bad++; end
  endtask

  task automatic test_load_use();
    clr_counters();
    hz.ex_mem_r_en = 1'b1; hz.ex_wb_en = 1'b1; hz.ex_reg_dest = 5'd5;
    hz.id_uses_rs = 1'b1; hz.id_rs = 5'd5; hz.id_rt = 5'd9;
    #1;
    n_cmp++; if (outs() !== O_LU) begin $display("FAIL load_use_rs got %b want %b", outs(), O_LU); n_bad++; end
    cyc();
    idle();  // load has moved to MEM
    #1;
    n_cmp++; if (outs() !== O_RUN) begin $display("FAIL load_use_after got %b want %b", outs(), O_RUN); n_bad++; end
    cyc();
    n_cmp++; if (stall_cycles !== 4'd1) begin $display("FAIL load_use_stalls got %0d want 1", stall_cycles); n_bad++; end
    // rt match
    hz.ex_mem_r_en = 1'b1; hz.ex_wb_en = 1'b1; hz.ex_reg_dest = 5'd7;
    hz.id_uses_rt = 1'b1; hz.id_rt = 5'd7;
    #1;
    n_cmp++; if (outs() !== O_LU) begin $display("FAIL load_use_rt got %b want %b", outs(), O_LU); n_bad++; end
    // $0 destination never stalls
    hz.ex_reg_dest = 5'd0; hz.id_rt = 5'd0; hz.id_uses_rs = 1'b1; hz.id_rs = 5'd0;
    #1;
    n_cmp++; if (outs() !== O_RUN) begin $display("FAIL load_use_r0 got %b want %b", outs(), O_RUN); n_bad++; end
    // not a writeback: no hazard
    hz.ex_reg_dest = 5'd7; hz.id_rt = 5'd7; hz.ex_wb_en = 1'b0;
    #1;
    n_cmp++; if (outs() !== O_RUN) begin $display("FAIL load_use_nowb got %b want %b", outs(), O_RUN); n_bad++; end
    // register match but source not used
    hz.ex_wb_en = 1'b1; hz.id_uses_rt = 1'b0; hz.id_uses_rs = 1'b0;
    #1;
    n_cmp++; if (outs() !== O_RUN) begin $display("FAIL load_use_unused got %b want %b", outs(), O_RUN); n_bad++; end
    cyc();
    n_cmp++; if (stall_cycles !== 4'd1) begin $display("FAIL load_use_stalls2 got %0d want 1", stall_cycles); n_bad++; end
  endtask

  task automatic test_branch();
    clr_counters();
    hz.br_taken_ex = 1'b1;
    hz.ex_mem_r_en = 1'b1; hz.ex_wb_en = 1'b1; hz.ex_reg_dest = 5'd3;
    hz.id_uses_rs = 1'b1; hz.id_rs = 5'd3;
    #1;
    n_cmp++; if (outs() !== O_BR) begin $display("FAIL branch_outs got %b want %b", outs(), O_BR); n_bad++; end
    cyc();
    idle();
    #1;
    n_cmp++; if (flush_count !== 4'd1 || stall_cycles !== 4'd0) begin
      $display("FAIL branch_cnt got %0d/%0d want 1/0", flush_count, stall_cycles); n_bad++; end
    // md_done in RUN is ignored
    hz.md_done = 1'b1;
    #1;
    n_cmp++; if (outs() !== O_RUN) begin $display("FAIL run_md_done got %b want %b", outs(), O_RUN); n_bad++; end
    cyc();
    hz.md_done = 1'b0;
    n_cmp++; if (hz.busy_md !== 1'b0) begin $display("FAIL run_md_done_busy got %b want 0", hz.busy_md); n_bad++; end
  endtask

  task automatic test_md();
    clr_counters();
    hz.ex_md_op = 1'b1;
    #1;
    n_cmp++; if (outs() !== O_MDST) begin $display("FAIL md_start got %b want %b", outs(), O_MDST); n_bad++; end
    for (int k = 1; k <= 4; k++) begin
      cyc();
      n_cmp++; if (outs() !== O_FREEZE || hz.busy_md !== 1'b1) begin
        $display("FAIL md_wait%0d got %b busy %b want %b busy 1", k, outs(), hz.busy_md, O_FREEZE); n_bad++; end
    end
    cyc();
    hz.md_done = 1'b1;
    #1;
    n_cmp++; if (outs() !== O_RUN || hz.busy_md !== 1'b1) begin
      $display("FAIL md_release got %b busy %b want %b busy 1", outs(), hz.busy_md, O_RUN); n_bad++; end
    cyc();
    idle();
    #1;
    n_cmp++; if (outs() !== O_RUN || hz.busy_md !== 1'b0) begin
      $display("FAIL md_after got %b busy %b want %b busy 0", outs(), hz.busy_md, O_RUN); n_bad++; end
    n_cmp++; if (stall_cycles !== 4'd5) begin $display("FAIL md_stalls got %0d want 5", stall_cycles); n_bad++; end
  endtask

  task automatic test_md_mem_stall();
    clr_counters();
    hz.ex_md_op = 1'b1;
    cyc();
    hz.ex_md_op = 1'b0;
    hz.mem_access = 1'b1; hz.dmem_ready = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      hz.md_done = (k == 2);
      #1;
      n_cmp++; if (outs() !== O_NONE || hz.busy_md !== 1'b1) begin
        $display("FAIL md_memstall%0d got %b busy %b want %b busy 1", k, outs(), hz.busy_md, O_NONE); n_bad++; end
      cyc();
    end
    idle();
    #1;
    n_cmp++; if (outs() !== O_RUN || hz.busy_md !== 1'b1) begin
      $display("FAIL md_pending_release got %b busy %b want %b busy 1", outs(), hz.busy_md, O_RUN); n_bad++; end
    cyc();
    n_cmp++; if (hz.busy_md !== 1'b0) begin $display("FAIL md_pending_exit got %b want 0", hz.busy_md); n_bad++; end
    n_cmp++; if (stall_cycles !== 4'd4) begin $display("FAIL md_memstall_stalls got %0d want 4", stall_cycles); n_bad++; end
  endtask

  task automatic test_reset_mid_md();
    clr_counters();
    hz.ex_md_op = 1'b1;
    cyc();
    hz.ex_md_op = 1'b0;
    // leave a pending result behind, then reset
    hz.mem_access = 1'b1; hz.dmem_ready = 1'b0; hz.md_done = 1'b1;
    cyc();
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (hz.busy_md !== 1'b0 || outs() !== O_NONE) begin
      $display("FAIL mid_reset got %b busy %b want %b busy 0", outs(), hz.busy_md, O_NONE); n_bad++; end
    cyc();
    rst_n = 1'b1;
    cyc();
    hz.ex_md_op = 1'b1;
    #1;
    n_cmp++; if (outs() !== O_MDST) begin $display("FAIL reset_md_start got %b want %b", outs(), O_MDST); n_bad++; end
    cyc();
    hz.ex_md_op = 1'b0;
    #1;
    n_cmp++; if (outs() !== O_FREEZE) begin $display("FAIL no_stale_release got %b want %b", outs(), O_FREEZE); n_bad++; end
    hz.md_done = 1'b1;
    cyc();
    idle();
    #1;
    n_cmp++; if (hz.busy_md !== 1'b0) begin $display("FAIL reset_md_exit got %b want 0", hz.busy_md); n_bad++; end
  endtask

  task automatic test_saturation();
    clr_counters();
    hz.mem_access = 1'b1; hz.dmem_ready = 1'b0;
    for (int k = 0; k < 20; k++) cyc();
    n_cmp++; if (stall_cycles !== 4'd15) begin $display("FAIL stall_saturate got %0d want 15", stall_cycles); n_bad++; end
    cnt_clr = 1'b1;
    cyc();
    cnt_clr = 1'b0;
    n_cmp++; if (stall_cycles !== 4'd0) begin $display("FAIL clr_during_stall got %0d want 0", stall_cycles); n_bad++; end
    cyc();
    n_cmp++; if (stall_cycles !== 4'd1) begin $display("FAIL stall_after_clr got %0d want 1", stall_cycles); n_bad++; end
    idle();
    // 17 taken branches saturate the flush counter
    hz.br_taken_ex = 1'b1;
    for (int k = 0; k < 17; k++) cyc();
    idle();
    n_cmp++; if (flush_count !== 4'd15) begin $display("FAIL flush_saturate got %0d want 15", flush_count); n_bad++; end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_md();
    test_md_mem_stall();
    test_reset_mid_md();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the 5-stage core. It decides each cycle which pipeline registers advance, hold or take a bubble, based on load-use hazards in ID, branches resolved in EX, the multi-cycle multiply/divide unit and data-memory wait states. Hazards the forwarding network cannot cover are handled here. It also keeps saturating stall and flush performance counters.

## Interface
- CNT_W, default 16: width of each performance counter.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous reset, active low.
- id_rs, id_rt  in  5 each  source registers of the instruction in ID.
- id_uses_rs, id_uses_rt  in  1 each  the ID instruction reads that source.
- ex_reg_dest  in  5  destination register of the instruction in EX.
- ex_wb_en, ex_mem_r_en  in  1 each  the EX instruction writes back / is a load.
- ex_md_op  in  1  the EX instruction is a multiply/divide.
- md_done  in  1  one-cycle pulse from the MD unit when its result is valid.
- br_taken_ex  in  1  a branch resolved taken in EX.
- mem_access, dmem_ready  in  1 each  MEM stage accesses memory / memory completes this cycle.
- cnt_clr  in  1  synchronous clear of both counters.
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  register advance enables.
- if_id_flush, id_ex_flush, ex_mem_flush  out  1 each  load a bubble when enabled.
- md_start  out  1  one-cycle launch pulse to the MD unit.
- busy_md  out  1  state is MD_WAIT.
- stall_cycles, flush_count  out  CNT_W each  performance counters.

## Operation
- State register: RUN (reset) or MD_WAIT. A md_pending flag also resets to 0.
- mem_stall = mem_access & ~dmem_ready.
- load_use = ex_mem_r_en & ex_wb_en & ex_reg_dest≠0 & ((id_uses_rs & id_rs==ex_reg_dest) | (id_uses_rt & id_rt==ex_reg_dest)).
- "Front freeze" means: pc_en=if_id_en=id_ex_en=0, ex_mem_en=1 with ex_mem_flush=1, mem_wb_en=1.
- RUN, first matching case applies:
  1. mem_stall: all enables 0, all flushes 0, md_start=0, state held.
  2. br_taken_ex: all enables 1, if_id_flush=id_ex_flush=1. This case masks load_use.
  3. ex_md_op: md_start=1 and front freeze; next state MD_WAIT.
  4. load_use: pc_en=if_id_en=0, id_ex_flush=1, other enables 1.
  5. Otherwise: all enables 1, no flushes.
- MD_WAIT, first matching case applies:
  1. mem_stall: all enables 0; if md_done, set md_pending.
  2. md_done | md_pending: all enables 1, no flushes, md_pending cleared, next state RUN.
  3. Otherwise: front freeze.
- md_done in RUN is ignored. md_start is never asserted in MD_WAIT.
- stall_cycles increments in every cycle where pc_en=0.
- flush_count increments in every cycle where RUN case 2 fires.
- Both counters saturate at 2^CNT_W−1. cnt_clr wins over an increment in the same cycle.
- During rst_n=0: all enables 0, all flushes 0, md_start=0, busy_md=0, counters 0.

## Timing
- All enable, flush and md_start outputs are combinational from the current state, md_pending and the inputs. There is zero-cycle latency from a hazard to its stall.
- State, md_pending and the counters update on the rising clk edge.
- Reset acts asynchronously at any time, including mid-MD_WAIT. It forces RUN, clears md_pending, and the MD result is discarded.
- A load-use hazard costs exactly 1 bubble. In the next cycle the load is in MEM, so forwarding resolves the dependency and load_use reads 0.
- An MD op with md_done N cycles after md_start costs N stall cycles. The release cycle latches the MD result into EX/MEM.
- A memory stall freezes every stage for exactly as many cycles as dmem_ready stays low.

## Test plan
- EX: lw $5 with wb_en=1, ex_mem_r_en=1. ID: add using rs=$5. Expected: pc_en=0 and id_ex_flush=1 for 1 cycle, then all enables 1; stall_cycles=1.
- Same lw, but rd=$0 and ID rs=$0. Expected: no stall.
- Branch taken in EX while ID has a load_use match. Expected: if_id_flush=id_ex_flush=1, pc_en=1; flush_count=1, stall_cycles=0.
- ex_md_op asserted, md_done 5 cycles later. Expected: md_start for 1 cycle; busy_md high for 5 cycles; ex_mem_flush=1 while frozen; stall_cycles=5; release cycle has all enables 1.
- In MD_WAIT, mem_stall for 3 cycles with md_done pulsing in the 2nd of them. Expected: all enables 0 for those 3 cycles, then release on the 4th cycle with md_done low.
- Assert rst_n=0 mid-MD_WAIT. Expected: busy_md=0 immediately; after reset, RUN with no stale release.
- With CNT_W=4, hold 20 stall cycles. Expected: stall_cycles=15. Then pulse cnt_clr during a stall. Expected: stall_cycles=0.
